gam_two_min_search: RTL
=======================

// Module: gam_two_min_search
// PURPOSE
//  Winner-search stage for the memory layer. On start, it scans the stored node distance memory and finds
//  the nearest node (s1) and the second-nearest node (s2) to the current input.
//  It sits between the node distance memory and the memory layer controller, and runs while the
//  controller asserts its 2-min enable. Results feed the threshold compare and the W/T write-back of s1/s2.
// PARAMETERS
//  DIST_W    24   width of one distance word (unsigned squared Euclidean distance)
//  NODE_W    8    node index/address width; at most 2**NODE_W nodes
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse; starts a scan (ignored while busy)
//  num_nodes   in   NODE_W+1 live node count, sampled on start
//  rd_addr     out  NODE_W  distance memory read address
//  rd_en       out  1       read strobe; memory returns rd_data exactly 1 cycle later
//  rd_data     in   DIST_W  distance of node rd_addr (registered memory output)
//  busy        out  1       high from the cycle after an accepted start until done
//  done        out  1       1-cycle pulse; results are valid from this cycle until the next start
//  s1_valid    out  1       at least one node was scanned
//  s1_idx      out  NODE_W  index of the nearest node
//  s1_dist     out  DIST_W  distance of the nearest node
//  s2_valid    out  1       at least two nodes were scanned
//  s2_idx      out  NODE_W  index of the second-nearest node
//  s2_dist     out  DIST_W  distance of the second-nearest node
//  th_in       in   DIST_W  s1 threshold (only with GAM_TWO_MIN_THRESH_EN)
//  gt_th       out  1       s1_dist > th_in (only with GAM_TWO_MIN_THRESH_EN)
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; every output 0; the s1/s2 registers are cleared.
//  FSM: IDLE -> ISSUE -> SCAN -> DRAIN -> FIN -> IDLE.
//   IDLE : when start=1, latch N=num_nodes and clear the valids. If N=0, go to FIN; else go to ISSUE.
//   ISSUE: rd_en=1, rd_addr=0. Go to SCAN.
//   SCAN : rd_en=1, rd_addr increments by 1 each cycle. Each cycle it evaluates rd_data for address-1.
//          After issuing address N-1, go to DRAIN.
//   DRAIN: rd_en=0; evaluate the last node. Go to FIN.
//   FIN  : done=1 for one cycle; busy=0 from the next cycle.
//  Latency: with start at cycle 0, done is asserted at cycle N+3. For N=0, done is at cycle 2.
//  Compare, applied per returned word d with index k:
//   - if !s1_valid or d < s1_dist: s2 <= s1 (with s2_valid <= s1_valid); s1 <= (k,d).
//   - else if !s2_valid or d < s2_dist: s2 <= (k,d).
//   - Ties (d == s1_dist or d == s2_dist): the earlier index is kept. The scan is ascending, so the lowest index wins.
//  All comparisons are unsigned, full DIST_W. There is no arithmetic; only comparisons and index counting.
//  Boundaries:
//   - N=1: s1_valid=1 and s2_valid=0 at done.
//   - N=2**NODE_W: rd_addr reaches all-ones and the scan stops without wrap. num_nodes is NODE_W+1 bits for this case.
//   - N > 2**NODE_W is clamped to 2**NODE_W.
//   - start while busy is ignored, with no restart.
//   - start in the FIN cycle is ignored; it is accepted from IDLE only.
//   - Async reset mid-scan aborts immediately. No done pulse is produced; the outputs clear.
//   - Result registers hold after done until the next accepted start.
// CONFIGURATION
//  GAM_TWO_MIN_THRESH_EN defined: gt_th is registered at FIN from the final s1_dist and th_in, and holds with the results.
//   gt_th=0 if !s1_valid.
//   It drives the controller's GREATER/LESS decision directly.
//  Not defined: the th_in and gt_th ports are absent and no comparator is synthesised.
//   The threshold compare is done downstream.
// TESTING
//  1. N=4, dist {50,20,30,10}, start@0 -> done@7; s1=(3,10), s2=(1,20); both valids=1.
//  2. N=3, dist {7,7,7} -> s1=(0,7), s2=(1,7) (tie keeps lowest index).
//  3. N=1, dist {99} -> s1=(0,99), s1_valid=1, s2_valid=0.
//     N=0 -> done@2, both valids=0, rd_en never asserted.
//  4. N=2**NODE_W, descending distances -> s1=(last,min), s2=(last-1,…); rd_addr never wraps to 0.
//  5. Reset low at cycle 3 of an N=8 scan -> outputs 0 immediately and no done.
//     A new start after release -> correct fresh result, with no stale s1/s2.
//  6. start held high through a scan -> a single scan and one done.
//     With GAM_TWO_MIN_THRESH_EN, th_in=15 on case 1 gives gt_th=0; th_in=9 gives gt_th=1.

Source files
------------

// File: rtl/gam_two_min_search.sv
// gam_two_min_search
//   Winner-search stage for the memory layer. On i_start it reads the node
//   distance memory over addresses 0..N-1. It returns the nearest node (s1)
//   and the second-nearest node (s2). Ties keep the lowest index.
//
// Parameters
//   DIST_W : width of one unsigned distance word
//   NODE_W : node index / address width (up to 2**NODE_W nodes)
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-low reset
//   i_start      1-cycle start pulse, accepted in IDLE only
//   i_num_nodes  live node count (NODE_W+1 bits), clamped to 2**NODE_W
//   o_rd_addr    distance memory read address
//   o_rd_en      read strobe; i_rd_data is valid one cycle later
//   i_rd_data    registered memory output
//   o_busy       scan in progress
//   o_done       1-cycle pulse; results valid until the next accepted start
//   o_s1_*       nearest node: valid / index / distance
//   o_s2_*       second-nearest node: valid / index / distance
//   i_th_in      s1 threshold          (GAM_TWO_MIN_THRESH_EN only)
//   o_gt_th      s1_dist > i_th_in     (GAM_TWO_MIN_THRESH_EN only)
//
// Optional feature macro: GAM_TWO_MIN_THRESH_EN

module gam_two_min_search #(
  parameter int unsigned DIST_W = 24,
  parameter int unsigned NODE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NODE_W:0]   i_num_nodes,
  output logic [NODE_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DIST_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
`ifdef GAM_TWO_MIN_THRESH_EN
  input  logic [DIST_W-1:0] i_th_in,
  output logic              o_gt_th,
`endif
  output logic              o_s1_valid,
  output logic [NODE_W-1:0] o_s1_idx,
  output logic [DIST_W-1:0] o_s1_dist,
  output logic              o_s2_valid,
  output logic [NODE_W-1:0] o_s2_idx,
  output logic [DIST_W-1:0] o_s2_dist
);

  typedef enum logic [2:0] {StIdle, StIssue, StScan, StDrain, StFin} state_e;

  state_e              r_state, w_state_next;
  logic [NODE_W-1:0]   r_addr, w_addr_next;
  logic [NODE_W-1:0]   r_last;   // last address to issue (N-1)
  logic [NODE_W-1:0]   r_k;      // index of the word now on i_rd_data
  logic                r_done;
  logic                r_s1_valid, r_s2_valid;
  logic [NODE_W-1:0]   r_s1_idx, r_s2_idx;
  logic [DIST_W-1:0]   r_s1_dist, r_s2_dist;
  logic                w_accept, w_eval, w_n_zero, w_lt1, w_lt2;
  logic [NODE_W-1:0]   w_start_last;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_n_zero = (i_num_nodes == '0);
  // MSB set means N >= 2**NODE_W: clamp so the scan ends at all-ones.
  assign w_start_last = i_num_nodes[NODE_W] ? '1 : (i_num_nodes[NODE_W-1:0] - NODE_W'(1));
  assign w_lt1 = i_rd_data < r_s1_dist;
  assign w_lt2 = i_rd_data < r_s2_dist;

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    o_rd_en      = 1'b0;
    w_eval       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = w_n_zero ? StFin : StIssue;
          w_addr_next  = '0;
        end
      end
      StIssue, StScan: begin
        o_rd_en = 1'b1;
        w_eval  = (r_state == StScan);
        if (r_addr == r_last) begin
          w_state_next = StDrain;
        end else begin
          w_state_next = StScan;
          w_addr_next  = r_addr + NODE_W'(1);
        end
      end
      StDrain: begin
        w_eval       = 1'b1;
        w_state_next = StFin;
      end
      StFin: begin
        w_state_next = StIdle;
        w_addr_next  = '0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_last  <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_done  <= (r_state == StFin);
      if (w_accept) r_last <= w_start_last;
      if (o_rd_en)  r_k    <= r_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_dist  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_dist  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_dist  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_dist  <= '0;
    end else if (w_eval) begin
      // Strict less-than: an equal later distance never displaces an earlier index.
      if (!r_s1_valid || w_lt1) begin
        r_s2_valid <= r_s1_valid;
        r_s2_idx   <= r_s1_idx;
        r_s2_dist  <= r_s1_dist;
        r_s1_valid <= 1'b1;
        r_s1_idx   <= r_k;
        r_s1_dist  <= i_rd_data;
      end else if (!r_s2_valid || w_lt2) begin
        r_s2_valid <= 1'b1;
        r_s2_idx   <= r_k;
        r_s2_dist  <= i_rd_data;
      end
    end
  end

`ifdef GAM_TWO_MIN_THRESH_EN
  logic r_gt_th;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_gt_th <= 1'b0;
    end else if (w_accept) begin
      r_gt_th <= 1'b0;
    end else if (r_state == StFin) begin
      r_gt_th <= r_s1_valid && (r_s1_dist > i_th_in);
    end
  end
  assign o_gt_th = r_gt_th;
`endif

  assign o_rd_addr  = r_addr;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_s1_valid = r_s1_valid;
  assign o_s1_idx   = r_s1_idx;
  assign o_s1_dist  = r_s1_dist;
  assign o_s2_valid = r_s2_valid;
  assign o_s2_idx   = r_s2_idx;
  assign o_s2_dist  = r_s2_dist;

endmodule
